// File: rtl/axi4l_ram.sv
// AXI4-Lite slave RAM: byte-strobed synchronous storage with independent AW/W capture and held R data.
// Define AXI4L_RAM_ERRCHK_EN to return SLVERR for addresses beyond SIZE (otherwise addresses alias).
module axi4l_ram #(
  parameter int unsigned SIZE       = 'h1000,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned SIZE_W = $clog2(SIZE);
  localparam int unsigned DEPTH  = SIZE / STRB_W;
  localparam int unsigned IDX_W  = SIZE_W - OFF_W;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_HAVE_AW, S_HAVE_W, S_RESP} wstate_e;

  wstate_e r_state, w_next;
  logic w_awready, w_wready, w_bvalid;
  logic w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [ADDR_WIDTH-1:0] r_awaddr, w_wr_addr;
  logic [DATA_WIDTH-1:0] r_wdata, w_wr_data;
  logic [STRB_W-1:0]     r_wstrb, w_wr_strb;
  logic [IDX_W-1:0]      w_wr_idx, w_rd_idx;
  logic                  w_wr_oor, w_rd_oor;
  logic [1:0]            r_bresp, r_rresp;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_unused;

  assign awready = w_awready && !areset;
  assign wready  = w_wready && !areset;
  assign bvalid  = w_bvalid;
  assign bresp   = r_bresp;
  assign arready = (!r_rvalid || rready) && !areset;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;
  assign w_ar_hs = arvalid && arready;

  // Write FSM state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_aw_hs && w_w_hs) w_next = S_RESP;
        else if (w_aw_hs)      w_next = S_HAVE_AW;
        else if (w_w_hs)       w_next = S_HAVE_W;
      end
      S_HAVE_AW: if (w_w_hs)  w_next = S_RESP;
      S_HAVE_W:  if (w_aw_hs) w_next = S_RESP;
      S_RESP:    if (bready)  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_bvalid  = 1'b0;
    unique case (r_state)
      S_IDLE:    begin w_awready = 1'b1; w_wready = 1'b1; end
      S_HAVE_AW: w_wready  = 1'b1;
      S_HAVE_W:  w_awready = 1'b1;
      S_RESP:    w_bvalid  = 1'b1;
      default:   w_bvalid  = 1'b0;
    endcase
  end

  // Completing write merges the captured channel with whichever one is live this cycle
  always_comb begin
    w_commit  = (r_state == S_IDLE && w_aw_hs && w_w_hs) ||
                (r_state == S_HAVE_AW && w_w_hs) ||
                (r_state == S_HAVE_W && w_aw_hs);
    w_wr_addr = (r_state == S_HAVE_AW) ? r_awaddr : awaddr;
    w_wr_data = (r_state == S_HAVE_W) ? r_wdata : wdata;
    w_wr_strb = (r_state == S_HAVE_W) ? r_wstrb : wstrb;
    w_wr_idx  = w_wr_addr[SIZE_W-1:OFF_W];
    w_rd_idx  = araddr[SIZE_W-1:OFF_W];
`ifdef AXI4L_RAM_ERRCHK_EN
    w_wr_oor  = (w_wr_addr >> SIZE_W) != '0;
    w_rd_oor  = (araddr >> SIZE_W) != '0;
`else
    w_wr_oor  = 1'b0;
    w_rd_oor  = 1'b0;
`endif
  end

  assign w_unused = &{1'b0, awaddr, araddr, r_awaddr};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= RESP_OKAY;
    end else begin
      if (w_aw_hs) r_awaddr <= awaddr;
      if (w_w_hs) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
      if (w_commit) r_bresp <= w_wr_oor ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Storage is not reset; byte lanes written per strobe
  always_ff @(posedge aclk) begin
    if (w_commit && !w_wr_oor) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (w_wr_strb[i]) r_mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
      end
    end
  end

  // Read data loads only on AR handshake, so it holds while the master stalls
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_oor ? '0 : r_mem[w_rd_idx];
      r_rresp  <= w_rd_oor ? RESP_SLVERR : RESP_OKAY;
    end else if (rready) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule
